// File: rtl/mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_ctrl
// Description : Single-outstanding bus controller between the load/store unit
//               and the block-RAM wrapper. Optional range fault: MEM_FAULT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_ctrl #(
    parameter int READ_LAT   = 2,
    parameter int ADDR_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ready,
    output logic        cpu_done,
    output logic [15:0] cpu_rdata,
    output logic        cpu_fault,
    output logic        ram_bus_mode,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_write_data,
    input  logic [15:0] ram_read_data
);

    localparam logic c_MODE_WRITE = 1'b1;
    localparam logic c_MODE_READ  = 1'b0;
    localparam int   c_CNT_W      = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(READ_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    generate
        if (READ_LAT < 1 || ADDR_LIMIT < 1) begin : g_param_check
            $error("mem_bus_ctrl: READ_LAT and ADDR_LIMIT must both be at least 1");
        end
    endgenerate

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic                 r_ready;
    logic                 r_done;
    logic                 w_done_nxt;
    logic [15:0]          r_rdata;
    logic [15:0]          w_rdata_nxt;
    logic                 r_mode;
    logic                 w_mode_nxt;
    logic [15:0]          r_ram_addr;
    logic [15:0]          w_addr_nxt;
    logic [15:0]          r_ram_wdata;
    logic [15:0]          w_wdata_nxt;
    logic                 w_addr_oor;
    logic                 w_accept;

    assign w_accept = (r_state == S_IDLE) && cpu_req;

`ifdef MEM_FAULT_EN
    logic r_fault;

    assign w_addr_oor = ({16'd0, cpu_addr} >= ADDR_LIMIT);

    // Fault flag rides alongside the single RESP cycle of a rejected access.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= w_accept && w_addr_oor;
        end
    end

    assign cpu_fault = r_fault;
`else
    assign w_addr_oor = 1'b0;
    assign cpu_fault  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_rdata_nxt = r_rdata;
        w_mode_nxt  = c_MODE_READ;
        w_addr_nxt  = r_ram_addr;
        w_wdata_nxt = r_ram_wdata;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_addr_oor) begin
                        w_state_nxt = S_RESP;
                        w_done_nxt  = 1'b1;
                        w_rdata_nxt = '0;
                    end else if (cpu_we) begin
                        w_state_nxt = S_WRITE;
                        w_mode_nxt  = c_MODE_WRITE;
                        w_addr_nxt  = cpu_addr;
                        w_wdata_nxt = cpu_wdata;
                    end else begin
                        w_state_nxt = S_READ;
                        w_addr_nxt  = cpu_addr;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            S_WRITE: begin
                w_state_nxt = S_RESP;
                w_done_nxt  = 1'b1;
            end
            S_READ: begin
                // Address is held for READ_LAT cycles so the RAM output has settled.
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = S_RESP;
                    w_done_nxt  = 1'b1;
                    w_rdata_nxt = ram_read_data;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_rdata     <= '0;
            r_mode      <= c_MODE_READ;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_ready     <= (w_state_nxt == S_IDLE);
            r_done      <= w_done_nxt;
            r_rdata     <= w_rdata_nxt;
            r_mode      <= w_mode_nxt;
            r_ram_addr  <= w_addr_nxt;
            r_ram_wdata <= w_wdata_nxt;
        end
    end

    assign cpu_ready      = r_ready;
    assign cpu_done       = r_done;
    assign cpu_rdata      = r_rdata;
    assign ram_bus_mode   = r_mode;
    assign ram_addr       = r_ram_addr;
    assign ram_write_data = r_ram_wdata;

endmodule
`default_nettype wire

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
Memory bus controller between the CPU core's load/store unit and the RAM wrapper (1K-word block RAM with green-LED write mirror). It accepts single-word requests over a ready/req handshake and drives ram_bus_mode, ram_addr and ram_write_data as clean registered signals. It absorbs the block RAM's read latency and returns read data with a one-cycle done pulse. It serialises accesses: one outstanding request at a time.

Parameters:
READ_LAT, 2, cycles ram_addr is held in READ state before ram_read_data is captured (min 1)
ADDR_LIMIT, 1024, number of implemented RAM words; used only by the fault check

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
cpu_req  input  1  CPU request strobe
cpu_we  input  1  1 = write, 0 = read
cpu_addr  input  16  word address
cpu_wdata  input  16  write data
cpu_ready  output  1  controller can accept a request this cycle
cpu_done  output  1  one-cycle completion pulse (reads and writes)
cpu_rdata  output  16  read data, valid while cpu_done=1
cpu_fault  output  1  out-of-range access flag (MEM_FAULT_EN only, else tied 0)
ram_bus_mode  output  1  to RAM; MODE_WRITE (1) / MODE_READ (0) from const.vh
ram_addr  output  16  to RAM address
ram_write_data  output  16  to RAM write data
ram_read_data  input  16  from RAM read data

Behaviour:
- Reset (sync, high): state=IDLE, cpu_ready=1, cpu_done=0, cpu_fault=0, cpu_rdata=0, ram_bus_mode=MODE_READ, ram_addr=0, ram_write_data=0, latency counter=0.
- All outputs registered; no combinational path cpu_* to ram_*.
- Accept: rising edge with state=IDLE and cpu_req=1. cpu_we, cpu_addr and cpu_wdata are sampled only on that edge. cpu_ready=1 only in IDLE. cpu_req while not ready is ignored (not queued).
- States: IDLE, WRITE, READ, RESP.
- Write, accepted at edge t:
  - Cycle t+1: state WRITE, ram_bus_mode=MODE_WRITE, ram_addr/ram_write_data = sampled values. MODE_WRITE lasts exactly one cycle.
  - Cycle t+2: RESP, cpu_done=1, ram_bus_mode=MODE_READ.
  - Cycle t+3: IDLE.
- Read, accepted at edge t:
  - Cycles t+1 .. t+READ_LAT: state READ, ram_bus_mode=MODE_READ, ram_addr held.
  - Edge ending the last READ cycle: cpu_rdata <= ram_read_data.
  - Cycle t+READ_LAT+1: RESP, cpu_done=1.
  - Then IDLE.
- Latency: write 2 cycles accept-to-done; read READ_LAT+1.
- Back-to-back: the next request can be accepted in the first IDLE cycle after RESP. Minimum write issue interval is 3 cycles.
- ram_addr and ram_write_data keep their last values in IDLE/RESP. cpu_rdata holds until the next read capture.
- cpu_done is 0 in every state except RESP.
- Address width: full 16 bits are forwarded; the RAM uses bits [9:0], so addresses wrap modulo 1024 unless faulted.
- Reset mid-operation: the next state is IDLE and no cpu_done is issued.
  - If reset coincides with the edge ending a WRITE cycle, the RAM still commits that write, because MODE_WRITE was already presented on that edge.
  - If reset is asserted in the cycle before WRITE would be entered, no RAM write occurs.
- Simultaneous reset and cpu_req: reset wins; the request is dropped.

Optional Feature:
MEM_FAULT_EN
- Defined:
  - An accepted request with cpu_addr >= ADDR_LIMIT skips WRITE/READ and goes straight to RESP next cycle.
  - In RESP: cpu_done=1, cpu_fault=1, cpu_rdata=0.
  - ram_bus_mode stays MODE_READ and ram_addr is not updated.
  - cpu_fault is 0 in all other cycles.
- Undefined: no range check, cpu_fault is constant 0, and out-of-range addresses wrap in the RAM.

Test Plan:
- Reset, then idle 5 cycles -> cpu_ready=1, ram_bus_mode=0, ram_addr=0, cpu_done=0 throughout.
- Write addr 0x0010 data 0xBEEF accepted at t -> ram_bus_mode=1 only at t+1 with ram_addr=0x0010, ram_write_data=0xBEEF; cpu_done=1 at t+2; cpu_ready=1 at t+3.
- Read addr 0x0010 after the above, READ_LAT=2 -> ram_addr=0x0010 at t+1..t+2; cpu_done=1 and cpu_rdata=0xBEEF at t+3.
- cpu_req held high continuously alternating write/read -> exactly one access per handshake, no extra MODE_WRITE cycles, no double done pulses.
- Reset asserted during READ state -> IDLE the next cycle, no cpu_done, cpu_ready=1.
- MEM_FAULT_EN defined, write to 0x0400 -> cpu_done=1 and cpu_fault=1 one cycle after accept, ram_bus_mode never 1. Undefined: the same write lands at RAM word 0x000.
